// File: rtl/my_mux_16_8_way.sv
// 8-way 16-bit multiplexer; sel picks one of inputs a..h.
`ifndef MY_MUX_16_8_WAY_SV
`define MY_MUX_16_8_WAY_SV

module my_mux_16_8_way (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = '0;
        endcase
    end

endmodule

`endif

// File: rtl/my_register_16.sv
// 16-bit register with load enable and synchronous active-high reset to zero.

module my_register_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in_data,
    output logic [15:0] out_data
);

    logic [15:0] data_q;
    logic [15:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: rtl/my_fifo_16_8.sv
// 8-entry 16-bit first-word-fall-through FIFO with valid/ready on both sides.
// Head is read combinationally from storage through my_mux_16_8_way.

module my_fifo_16_8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        overflow,
    output logic        underflow
);

    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        push;
    logic        pop;
    logic [7:0]  wr_load;
    logic [15:0] mem [8];

    assign in_ready  = (count_q != 4'd8);
    assign out_valid = (count_q != 4'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // One-hot write enable; a flushed push must not touch storage either.
    always_comb begin
        wr_load = '0;
        if (push && !flush) begin
            wr_load = 8'b0000_0001 << wr_ptr_q;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_store
        my_register_16 u_reg (
            .clk      (clk),
            .reset    (reset),
            .load     (wr_load[i]),
            .in_data  (in_data),
            .out_data (mem[i])
        );
    end

    my_mux_16_8_way u_mux (
        .a   (mem[0]),
        .b   (mem[1]),
        .c   (mem[2]),
        .d   (mem[3]),
        .e   (mem[4]),
        .f   (mem[5]),
        .g   (mem[6]),
        .h   (mem[7]),
        .sel (rd_ptr_q),
        .out (out_data)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (in_valid & ~in_ready);
        underflow_d = underflow_q | (out_ready & ~out_valid);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 3'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_my_fifo_16_8.sv
// Directed bench for my_fifo_16_8 with hand-computed expectations.

module tb_my_fifo_16_8;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int unsigned n_tests;
    int unsigned n_fail;

    my_fifo_16_8 dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        idle();

        // Reset then idle
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0000);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // Fill to full
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h1000 + 16'(i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_data", 32'(out_data), 32'h1000);
        check("full_overflow_pre", 32'(overflow), 32'd0);
        in_data  = 16'hDEAD;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_head", 32'(out_data), 32'h1000);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'h1000 + 32'(i));
            step();
        end
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);
        check("drained_underflow_pre", 32'(underflow), 32'd0);
        step();
        out_ready = 1'b0;
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_overflow_kept", 32'(overflow), 32'd1);

        // Wrap with concurrent traffic
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h2000 + 16'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("wrap_pre_data", 32'(out_data), 32'h2000 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("wrap_pre_count", 32'(count), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h3000;
        step();
        check("wrap_seed_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = 16'h3001 + 16'(k);
            check("wrap_head", 32'(out_data), 32'h3000 + 32'(k));
            step();
            check("wrap_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        check("wrap_last", 32'(out_data), 32'h300C);
        step();
        out_ready = 1'b0;
        check("wrap_empty", 32'(count), 32'd0);

        // Full plus simultaneous pop
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h4000 + 16'(i);
            step();
        end
        check("fp_full", 32'(count), 32'd8);
        in_data   = 16'hBEEF;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("fp_count", 32'(count), 32'd7);
        check("fp_in_ready", 32'(in_ready), 32'd1);
        check("fp_head", 32'(out_data), 32'h4001);
        for (int i = 1; i < 8; i++) begin
            check("fp_drain", 32'(out_data), 32'h4000 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("fp_empty", 32'(out_valid), 32'd0);

        // Flush
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'h5000 + 16'(i);
            step();
        end
        check("fl_count3", 32'(count), 32'd3);
        flush     = 1'b1;
        in_data   = 16'h5555;
        out_ready = 1'b1;
        step();
        idle();
        check("fl_count", 32'(count), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_overflow", 32'(overflow), 32'd1);
        check("fl_underflow", 32'(underflow), 32'd1);

        // Reset wins over flush and push
        in_valid = 1'b1;
        in_data  = 16'h6000;
        step();
        reset    = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        idle();
        check("rp_count", 32'(count), 32'd0);
        check("rp_in_ready", 32'(in_ready), 32'd1);
        check("rp_out_valid", 32'(out_valid), 32'd0);
        check("rp_out_data", 32'(out_data), 32'h0000);
        check("rp_overflow", 32'(overflow), 32'd0);
        check("rp_underflow", 32'(underflow), 32'd0);
        // Walk rd_ptr across every slot; each stale head must be zero.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(i);
            step();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("rp_walk_head", 32'(out_data), 32'hA000 + 32'(i));
            step();
            out_ready = 1'b0;
            check("rp_stale_zero", 32'(out_data), 32'h0000);
        end
        check("rp_underflow_end", 32'(underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/my_fifo_16_8.md
Name: my_fifo_16_8

Overview:
- 8-entry, 16-bit first-word-fall-through FIFO.
- Storage is eight 16-bit registers. Read data is selected by the existing my_mux_16_8_way, with sel driven by the read pointer.
- Sits upstream of any 16-bit consumer that needs elastic buffering, e.g. between the CPU output path and a memory-mapped device.
- Valid/ready handshake on both sides.

Parameters:
- None overridable. Width is fixed at 16 and depth at 8, both set by my_mux_16_8_way.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous empty request; lower priority than reset
- in_data  input  16  write data
- in_valid  input  1  producer offers in_data
- in_ready  output  1  FIFO can accept this cycle
- out_data  output  16  head entry, i.e. mem[rd_ptr] via my_mux_16_8_way
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes head this cycle
- count  output  4  occupancy, 0..8
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state (one cycle after reset=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0, all 8 storage registers=16'h0000.
  - in_ready=1, out_valid=0, out_data=16'h0000, overflow=0, underflow=0.
- Reset mid-operation discards all contents and any handshake in that cycle. There is no push or pop on a reset cycle.
- Combinational outputs:
  - in_ready = (count != 8).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr]. There is no registered output stage.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid and out_ready may be asserted freely; only the qualified push and pop take effect.
- On push:
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, 3-bit wrap 7->0.
- On pop:
  - rd_ptr <= rd_ptr+1, 3-bit wrap 7->0.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- Latency:
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 the cycle after the push edge.
  - There is no same-cycle bypass from in_data to out_data.
- Full (count=8):
  - in_ready=0, so no push.
  - A pop is allowed; in_ready returns to 1 the next cycle.
  - in_valid=1 while full sets overflow.
- Empty (count=0):
  - out_valid=0, so no pop.
  - A push is allowed.
  - out_ready=1 while empty sets underflow.
  - out_data holds mem[rd_ptr], which is stale but deterministic.
- Simultaneous push and pop with 0<count<8: both pointers advance and count holds.
- Pointer wrap:
  - wr_ptr==rd_ptr is ambiguous; count alone distinguishes full from empty.
  - Pointers never carry a 4th bit.
- flush (when reset=0):
  - Next cycle: wr_ptr=0, rd_ptr=0, count=0.
  - A push or pop in the same cycle is ignored.
  - Storage contents and the sticky flags are untouched.
- Sticky flags clear only on reset.
- Write decode: a one-hot load per register, wr_ptr decoded and gated by push. This is equivalent to a DMux8Way.

Decomposition:
- No new package. Width and depth are fixed by the existing 16-bit mux family.
- Include my_mux_16_8_way behind its `ifndef guard.
- Natural sub-module: my_register_16, a 16-bit register with load enable and synchronous active-high reset to 0, instantiated 8 times.
- Pointer and count logic stays inline.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 1 cycle.
  - Required response: count=0, in_ready=1, out_valid=0, out_data=16'h0000, overflow=0, underflow=0.
- Fill to full:
  - Stimulus: push 16'h1000..16'h1007 on 8 back-to-back cycles with out_ready=0.
  - Required response: count=8, in_ready=0, out_data=16'h1000.
  - Follow-on: a 9th in_valid with 16'hDEAD leaves contents unchanged and sets overflow=1.
- Drain in order:
  - Stimulus: from full, hold out_ready=1.
  - Required response: out_data sequence 16'h1000..16'h1007 on consecutive cycles, then out_valid=0 and count=0.
  - Follow-on: one more out_ready cycle sets underflow=1.
- Wrap with concurrent traffic:
  - Stimulus: push 5 words, pop 5, then push and pop every cycle for 12 cycles with an incrementing pattern.
  - Required response: count stays 1 throughout; data order is preserved across the 7->0 wrap of both pointers.
- Full plus simultaneous pop:
  - Stimulus: at count=8, in_valid=1 and out_ready=1.
  - Required response: the pop occurs, the push does not; count=7 and in_ready=1 next cycle, out_data advances by one entry.
- Flush and reset priority:
  - Stimulus: at count=3, flush=1.
  - Required response: count=0 and out_valid=0 next cycle, flags unchanged.
  - Stimulus: reset=1 and flush=1 together with in_valid=1.
  - Required response: full reset state, flags cleared, storage all zero.
